// File: rtl/conv_pkg.sv
// Shared constants for the OFM post-processing stage: sample width, IFM side,
// kernel sizes, OFM-side helper and FSM state encodings.
package conv_pkg;

    localparam int DW    = 16;
    localparam int IFM_W = 8;
    localparam int BUF_D = (IFM_W - 2) / 2;
    localparam int K3    = 3;
    localparam int K5    = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int n_of(input int ifm_w, input int k);
        return ifm_w - k + 1;
    endfunction

endpackage

// File: rtl/ofmd_relu_maxpool_pool_lane.sv
// One pooling channel: optional ReLU, horizontal pair max, half-row buffer, vertical max.
// Optional build macro: RELU_EN (clamp negative samples to zero before pooling).
module pool_lane #(
    parameter int DW    = 16,
    parameter int BUF_D = 3,
    parameter int HW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic                 row_odd,
    input  logic                 col_odd,
    input  logic [HW-1:0]        hidx,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] dout,
    output logic                 vld
);
    import conv_pkg::*;

    logic signed [DW-1:0] v;
    logic signed [DW-1:0] pair;
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] hbuf [BUF_D];

    always_comb begin
`ifdef RELU_EN
        v = din[DW-1] ? '0 : din;
`else
        v = din;
`endif
        hmax = (v > pair) ? v : pair;
    end

    // Even rows park their pair maxima; odd rows fold them into the final 2x2 result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pair <= '0;
            dout <= '0;
            vld  <= 1'b0;
            for (int i = 0; i < BUF_D; i++) hbuf[i] <= '0;
        end else begin
            vld <= 1'b0;
            if (accept) begin
                if (!col_odd) begin
                    pair <= v;
                end else if (!row_odd) begin
                    hbuf[hidx] <= hmax;
                end else begin
                    dout <= (hbuf[hidx] > hmax) ? hbuf[hidx] : hmax;
                    vld  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ofmd_relu_maxpool.sv
// ReLU + 2x2/stride-2 max pooling of the two conv OFM streams; owns frame FSM and counters.
// Optional build macro: RELU_EN (passed through to both lanes).
//
// state   | meaning
// IDLE    | waiting for in_st
// RUN     | accepting N*N samples, row-major
// DONE    | frame complete, out_done high for one cycle
module ofmd_relu_maxpool #(
    parameter int DW    = conv_pkg::DW,
    parameter int IFM_W = conv_pkg::IFM_W,
    parameter int BUF_D = conv_pkg::BUF_D
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kw_is_5_5,
    input  logic                 in_st,
    input  logic signed [DW-1:0] din_ofmd1,
    input  logic signed [DW-1:0] din_ofmd2,
    output logic signed [DW-1:0] dout_pool1,
    output logic signed [DW-1:0] dout_pool2,
    output logic                 dout_vld,
    output logic                 out_done
);
    import conv_pkg::*;

    localparam int CW = $clog2(IFM_W);
    localparam int HW = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam logic [CW-1:0] N3_LAST = CW'(n_of(IFM_W, K3) - 1);
    localparam logic [CW-1:0] N5_LAST = CW'(n_of(IFM_W, K5) - 1);

    logic [1:0]    state;
    logic [CW-1:0] n_last;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic [HW-1:0] hidx;
    logic          vld1;
    logic          vld2;

    // A restart pulse takes the cycle; the first sample of the new frame follows it.
    assign accept   = (state == ST_RUN) && !in_st;
    assign hidx     = HW'(col >> 1);
    assign out_done = (state == ST_DONE);
    assign dout_vld = vld1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            n_last <= '0;
            row    <= '0;
            col    <= '0;
        end else if (in_st) begin
            state  <= ST_RUN;
            n_last <= kw_is_5_5 ? N5_LAST : N3_LAST;
            row    <= '0;
            col    <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (col == n_last) begin
                        col <= '0;
                        if (row == n_last) begin
                            row   <= '0;
                            state <= ST_DONE;
                        end else begin
                            row <= row + CW'(1);
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_IDLE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    pool_lane #(.DW(DW), .BUF_D(BUF_D), .HW(HW)) u_lane1 (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .row_odd (row[0]),
        .col_odd (col[0]),
        .hidx    (hidx),
        .din     (din_ofmd1),
        .dout    (dout_pool1),
        .vld     (vld1)
    );

    // Lane 2 shares the cadence, so its valid is identical to lane 1's.
    pool_lane #(.DW(DW), .BUF_D(BUF_D), .HW(HW)) u_lane2 (
        .clk     (clk),
        .rst     (rst),
        .accept  (accept),
        .row_odd (row[0]),
        .col_odd (col[0]),
        .hidx    (hidx),
        .din     (din_ofmd2),
        .dout    (dout_pool2),
        .vld     (vld2)
    );

    logic unused_vld2;
    assign unused_vld2 = vld2;

endmodule

// File: tb/tb_ofmd_relu_maxpool.sv
// Directed bench for ofmd_relu_maxpool with a scoreboard of expected pooled pairs.
module tb_ofmd_relu_maxpool;
    localparam int DW = 16;
`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        int   p1;
        int   p2;
        logic last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 kw_is_5_5 = 1'b0;
    logic                 in_st = 1'b0;
    logic signed [DW-1:0] din_ofmd1 = '0;
    logic signed [DW-1:0] din_ofmd2 = '0;
    logic signed [DW-1:0] dout_pool1;
    logic signed [DW-1:0] dout_pool2;
    logic                 dout_vld;
    logic                 out_done;

    int   tests = 0;
    int   fails = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    exp_t exp_q[$];
    int   d1[36];
    int   d2[36];

    always #5 clk = ~clk;

    ofmd_relu_maxpool dut (
        .clk        (clk),
        .rst        (rst),
        .kw_is_5_5  (kw_is_5_5),
        .in_st      (in_st),
        .din_ofmd1  (din_ofmd1),
        .din_ofmd2  (din_ofmd2),
        .dout_pool1 (dout_pool1),
        .dout_pool2 (dout_pool2),
        .dout_vld   (dout_vld),
        .out_done   (out_done)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int act(input int x);
        if (RELU && x < 0) return 0;
        return x;
    endfunction

    function automatic int pool_of(input bit ch2, input int i0, input int n);
        int a, b, c, d, m;
        a = act(ch2 ? d2[i0]       : d1[i0]);
        b = act(ch2 ? d2[i0+1]     : d1[i0+1]);
        c = act(ch2 ? d2[i0+n]     : d1[i0+n]);
        d = act(ch2 ? d2[i0+n+1]   : d1[i0+n+1]);
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic push_expect(input int n, input int nsamp);
        for (int pr = 0; pr < n/2; pr++) begin
            for (int pc = 0; pc < n/2; pc++) begin
                int   i0;
                exp_t e;
                i0 = 2*pr*n + 2*pc;
                if (i0 + n + 1 < nsamp) begin
                    e.p1   = pool_of(1'b0, i0, n);
                    e.p2   = pool_of(1'b1, i0, n);
                    e.last = (nsamp == n*n) && (pr == n/2-1) && (pc == n/2-1);
                    exp_q.push_back(e);
                end
            end
        end
        if (nsamp == n*n) done_exp++;
    endtask

    task automatic drive_frame(input bit k5, input int nsamp);
        push_expect(k5 ? 4 : 6, nsamp);
        @(posedge clk); #1;
        in_st     = 1'b1;
        kw_is_5_5 = k5;
        din_ofmd1 = 16'sh7abc;
        din_ofmd2 = 16'sh7abc;
        for (int i = 0; i < nsamp; i++) begin
            @(posedge clk); #1;
            in_st     = 1'b0;
            kw_is_5_5 = ~k5;
            din_ofmd1 = DW'(d1[i]);
            din_ofmd2 = DW'(d2[i]);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        in_st = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_done) begin
            done_seen++;
            chk("done_with_valid", dout_vld, 1);
        end
        if (dout_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("pool1", dout_pool1, e.p1);
                chk("pool2", dout_pool2, e.p2);
                chk("done_on_last", out_done, e.last);
            end
        end
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pool1", dout_pool1, 0);
        chk("rst_pool2", dout_pool2, 0);
        chk("rst_vld", dout_vld, 0);
        chk("rst_done", out_done, 0);
        rst = 1'b1;
        idle(2);

        // K=3 ramp
        for (int i = 0; i < 36; i++) begin d1[i] = i; d2[i] = 100 - 3*i; end
        drive_frame(1'b0, 36);
        idle(3);

        // K=5 ramp, negated ramp on ch2
        for (int i = 0; i < 36; i++) begin d1[i] = i; d2[i] = -i; end
        drive_frame(1'b1, 16);
        idle(3);

        // K=3 random signed on ch1, negated ramp on ch2
        for (int i = 0; i < 36; i++) begin
            d1[i] = int'($urandom_range(0, 2000)) - 1000;
            d2[i] = -i;
        end
        drive_frame(1'b0, 36);
        idle(3);

        // Abort after 20 samples; the pooled result of sample 19 is already in flight.
        for (int i = 0; i < 36; i++) begin d1[i] = i; d2[i] = -i; end
        drive_frame(1'b0, 20);
        for (int i = 0; i < 36; i++) begin d1[i] = 100 + i; d2[i] = 50 - i; end
        drive_frame(1'b0, 36);
        idle(3);

        // Async reset mid-frame at sample 15
        for (int i = 0; i < 36; i++) begin d1[i] = i; d2[i] = 7*i - 90; end
        drive_frame(1'b0, 15);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_pool1", dout_pool1, 0);
        chk("midrst_pool2", dout_pool2, 0);
        chk("midrst_vld", dout_vld, 0);
        chk("midrst_done", out_done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        for (int i = 0; i < 36; i++) begin d1[i] = i; d2[i] = -i; end
        drive_frame(1'b0, 36);
        idle(3);

        // Back-to-back: K=5 then K=3 started on the DONE cycle
        for (int i = 0; i < 36; i++) begin d1[i] = 3*i - 20; d2[i] = 40 - 2*i; end
        drive_frame(1'b1, 16);
        for (int i = 0; i < 36; i++) begin d1[i] = (i * 37) % 23 - 11; d2[i] = i; end
        drive_frame(1'b0, 36);
        idle(6);

        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_seen, done_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
